// File: rtl/serial_transmitter.sv
// Parallel-to-serial transmitter: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per enabled clock with first/last-bit frame strobes.
`timescale 1ns/1ps

module serial_transmitter #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [WIDTH-1:0] parallel_data_input,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic             serial_enable,
  output logic             serial_data_output,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_nextShift;
  logic [WIDTH-1:0] w_shifted;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_nextCount;
  logic             w_inShift;
  logic             w_lastBit;
  logic             w_accept;
  logic             w_outBit;

  assign w_inShift = (r_state == SHIFT);
  assign w_lastBit = w_inShift && (r_count == LAST_BIT);

  // A new word may only enter while idle or on the final enabled bit, which
  // is what makes back-to-back words gap-free.
  assign input_ready = !sync_reset && (!w_inShift || (w_lastBit && serial_enable));
  assign w_accept    = input_valid && input_ready;

  assign w_shifted = LSB_FIRST ? {1'b0, r_shift[WIDTH-1:1]}
                               : {r_shift[WIDTH-2:0], 1'b0};

  always_comb begin
    w_nextState = r_state;
    w_nextShift = r_shift;
    w_nextCount = r_count;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = SHIFT;
          w_nextShift = parallel_data_input;
          w_nextCount = '0;
        end
      end
      SHIFT: begin
        if (serial_enable) begin
          if (r_count == LAST_BIT) begin
            if (w_accept) begin
              w_nextShift = parallel_data_input;
              w_nextCount = '0;
            end else begin
              w_nextState = IDLE;
              w_nextShift = '0;
              w_nextCount = '0;
            end
          end else begin
            w_nextShift = w_shifted;
            w_nextCount = r_count + CW'(1);
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextShift = '0;
        w_nextCount = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_shift <= w_nextShift;
      r_count <= w_nextCount;
    end
  end

  assign w_outBit = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];

  assign serial_data_output = w_inShift && w_outBit;
  assign serial_valid       = w_inShift;
  assign busy               = w_inShift;
  assign frame_start        = w_inShift && (r_count == '0);
  assign frame_end          = w_lastBit;

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: MSB-first and LSB-first instances share inputs;
// a per-instance scoreboard checks every consumed bit and its frame strobes.
`timescale 1ns/1ps

module tb_serial_transmitter;

  localparam int W = 8;

  typedef struct {
    logic       rst;
    logic       valid;
    logic       en;
    logic [7:0] data;
    logic [5:0] expOut;
  } vec_t;

  typedef struct {
    logic bitVal;
    logic fs;
    logic fe;
  } sbEntry_t;

  logic         clk = 1'b0;
  logic         syncReset;
  logic [W-1:0] dataIn;
  logic         inValid;
  logic         serEn;

  logic readyMsb, sdoMsb, svMsb, fsMsb, feMsb, busyMsb;
  logic readyLsb, sdoLsb, svLsb, fsLsb, feLsb, busyLsb;

  int vectors     = 0;
  int miscompares = 0;

  sbEntry_t qMsb[$];
  sbEntry_t qLsb[$];
  vec_t     vecs[13];

  always #5 clk = ~clk;

  serial_transmitter #(.WIDTH(W), .LSB_FIRST(1'b0)) dutMsb (
    .clk                 (clk),
    .sync_reset          (syncReset),
    .parallel_data_input (dataIn),
    .input_valid         (inValid),
    .input_ready         (readyMsb),
    .serial_enable       (serEn),
    .serial_data_output  (sdoMsb),
    .serial_valid        (svMsb),
    .frame_start         (fsMsb),
    .frame_end           (feMsb),
    .busy                (busyMsb)
  );

  serial_transmitter #(.WIDTH(W), .LSB_FIRST(1'b1)) dutLsb (
    .clk                 (clk),
    .sync_reset          (syncReset),
    .parallel_data_input (dataIn),
    .input_valid         (inValid),
    .input_ready         (readyLsb),
    .serial_enable       (serEn),
    .serial_data_output  (sdoLsb),
    .serial_valid        (svLsb),
    .frame_start         (fsLsb),
    .frame_end           (feLsb),
    .busy                (busyLsb)
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic pushWord(input logic [W-1:0] w);
    sbEntry_t e;
    for (int k = 0; k < W; k++) begin
      e.fs = (k == 0);
      e.fe = (k == W - 1);
      e.bitVal = w[W-1-k];
      qMsb.push_back(e);
      e.bitVal = w[k];
      qLsb.push_back(e);
    end
  endtask

  // Consumer side: a bit is taken at every edge with serial_valid && serial_enable.
  always @(negedge clk) begin
    sbEntry_t e;
    if (svMsb && serEn) begin
      if (qMsb.size() == 0) check("msb unexpected bit", 8'd1, 8'd0);
      else begin
        e = qMsb.pop_front();
        check("msb bit/fs/fe", {5'd0, sdoMsb, fsMsb, feMsb}, {5'd0, e.bitVal, e.fs, e.fe});
      end
    end
    if (svLsb && serEn) begin
      if (qLsb.size() == 0) check("lsb unexpected bit", 8'd1, 8'd0);
      else begin
        e = qLsb.pop_front();
        check("lsb bit/fs/fe", {5'd0, sdoLsb, fsLsb, feLsb}, {5'd0, e.bitVal, e.fs, e.fe});
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    nextCycle();
    syncReset = v.rst;
    inValid   = v.valid;
    serEn     = v.en;
    dataIn    = v.data;
    #3;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    check($sformatf("vector %0d {ready,busy,sv,sdo,fs,fe}", idx),
          {2'b00, readyMsb, busyMsb, svMsb, sdoMsb, fsMsb, feMsb}, {2'b00, v.expOut});
  endtask

  task automatic sendWord(input logic [W-1:0] w);
    nextCycle();
    inValid = 1'b1;
    dataIn  = w;
    pushWord(w);
    #3;
    check("idle ready", {7'd0, readyMsb}, 8'd1);
    nextCycle();
    inValid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      nextCycle();
      #3;
      if (!busyMsb && !busyLsb && qMsb.size() == 0 && qLsb.size() == 0) done = 1'b1;
    end
    check({name, " drained to idle"}, {7'd0, done}, 8'd1);
  endtask

  initial begin
    int busyCycles;
    logic [7:0] c3;

    syncReset = 1'b1;
    inValid   = 1'b0;
    serEn     = 1'b1;
    dataIn    = '0;
    c3        = 8'hC3;

    // expOut = {ready, busy, serial_valid, sdo, frame_start, frame_end}
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'hC3, 6'b000000};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'hC3, 6'b000000};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'hC3, 6'b000000};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'hC3, 6'b100000};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 6'b011110};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 6'b011100};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 6'b011000};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 6'b011000};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 6'b011000};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 6'b011000};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 6'b011100};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 6'b111101};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 6'b100000};

    $display("[TB] reset and single 8'hC3 frame");
    for (int i = 0; i < 13; i++) begin
      if (i == 3) pushWord(8'hC3);
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end
    waitIdle("single frame");

    $display("[TB] bit order with 8'h0F");
    sendWord(8'h0F);
    waitIdle("bit order");

    $display("[TB] back-to-back 8'hC3, 8'h5A");
    nextCycle();
    inValid = 1'b1;
    dataIn  = 8'hC3;
    pushWord(8'hC3);
    #3;
    check("b2b first ready", {7'd0, readyMsb}, 8'd1);
    for (int i = 0; i < 16; i++) begin
      nextCycle();
      if (i == 0) begin
        dataIn = 8'h5A;
        pushWord(8'h5A);
      end
      if (i == 8) inValid = 1'b0;
      #3;
      check($sformatf("b2b cycle %0d {busy,ready,fs}", i),
            {5'd0, busyMsb, readyMsb, fsMsb},
            {5'd0, 1'b1, (i == 7 || i == 15) ? 1'b1 : 1'b0, (i == 0 || i == 8) ? 1'b1 : 1'b0});
    end
    nextCycle();
    #3;
    check("b2b idle after 16", {7'd0, busyMsb}, 8'd0);
    waitIdle("back-to-back");

    $display("[TB] stall while bit 3 on the line");
    nextCycle();
    inValid = 1'b1;
    dataIn  = 8'hC3;
    pushWord(8'hC3);
    #3;
    nextCycle();
    inValid    = 1'b0;
    busyCycles = 0;
    for (int c = 0; c < 30; c++) begin
      serEn = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      #3;
      if (!busyMsb) break;
      busyCycles++;
      if (c >= 3 && c <= 6)
        check($sformatf("stall cycle %0d held bit", c), {7'd0, sdoMsb}, 8'd0);
      nextCycle();
    end
    serEn = 1'b1;
    check("stalled frame length", 8'(busyCycles), 8'd11);
    waitIdle("stall");

    $display("[TB] reset mid-frame then 8'h81");
    nextCycle();
    inValid = 1'b1;
    dataIn  = 8'hC3;
    pushWord(8'hC3);
    #3;
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      inValid = 1'b0;
      #3;
    end
    nextCycle();
    syncReset = 1'b1;
    #3;
    check("ready during reset", {6'd0, busyMsb, readyMsb}, {6'd0, 1'b1, 1'b0});
    check("bit 4 on line", {7'd0, sdoMsb}, {7'd0, c3[3]});
    nextCycle();
    qMsb.delete();
    qLsb.delete();
    syncReset = 1'b0;
    #3;
    check("post-reset {busy,sv,sdo,fe}", {4'd0, busyMsb, svMsb, sdoMsb, feMsb}, 8'd0);
    sendWord(8'h81);
    waitIdle("reset recovery");

    $display("[TB] early valid ignored until last bit");
    nextCycle();
    inValid = 1'b1;
    dataIn  = 8'hC3;
    pushWord(8'hC3);
    #3;
    nextCycle();
    inValid = 1'b0;
    #3;
    nextCycle();
    #3;
    for (int b = 2; b < 8; b++) begin
      nextCycle();
      if (b == 2) begin
        inValid = 1'b1;
        dataIn  = 8'hFF;
        pushWord(8'hFF);
      end
      #3;
      check($sformatf("early valid bit %0d {ready,sdo}", b),
            {6'd0, readyMsb, sdoMsb}, {6'd0, (b == 7) ? 1'b1 : 1'b0, c3[7-b]});
    end
    nextCycle();
    inValid = 1'b0;
    #3;
    check("0xFF follows {busy,fs,sdo}", {5'd0, busyMsb, fsMsb, sdoMsb}, 8'd7);
    waitIdle("early valid");

    check("msb queue empty", 8'(qMsb.size()), 8'd0);
    check("lsb queue empty", 8'(qLsb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_transmitter.md
Name: serial_transmitter

Overview:
Parallel-to-serial transmitter that sources the serial bit stream consumed by the shift register's serial load path. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per enabled clock, MSB-first or LSB-first. It raises frame strobes on the first and last bit, and supports back-to-back words with no idle gap. It sits between a word producer and any serial-load register or link in the datapath.

Parameters:
WIDTH, 8, word width in bits; legal values are WIDTH >= 2.
LSB_FIRST, 0, 0 = transmit bit WIDTH-1 first; 1 = transmit bit 0 first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
sync_reset  input  1  synchronous, active-high reset.
parallel_data_input  input  WIDTH  word to transmit; sampled on handshake.
input_valid  input  1  producer has a word on parallel_data_input.
input_ready  output  1  transmitter accepts a word this cycle.
serial_enable  input  1  bit-advance enable; 0 stalls the transmitter.
serial_data_output  output  1  current serial bit.
serial_valid  output  1  serial_data_output carries a valid bit.
frame_start  output  1  current bit is the first bit of a word.
frame_end  output  1  current bit is the last bit of a word.
busy  output  1  word in flight (state SHIFT).

Behaviour:
- One clock, clk. sync_reset is synchronous and active-high, sampled on the rising edge.
- State: IDLE, SHIFT. Internal registers: WIDTH-bit shift register and a bit counter of $clog2(WIDTH) bits.
- Reset (sync_reset=1 at an edge): state=IDLE, shift register=0, counter=0.
  - Resulting outputs: serial_valid=0, serial_data_output=0, frame_start=0, frame_end=0, busy=0.
  - input_ready is forced 0 in any cycle where sync_reset=1.
  - Reset overrides every other input, including mid-frame. A partial word is discarded with no frame_end.
- Output decode (combinational from registers only):
  - serial_valid = busy = (state==SHIFT).
  - serial_data_output = shift register bit WIDTH-1 (LSB_FIRST=0) or bit 0 (LSB_FIRST=1); it is 0 in IDLE.
  - frame_start = SHIFT && count==0.
  - frame_end = SHIFT && count==WIDTH-1.
- input_ready = !sync_reset && (IDLE || (SHIFT && count==WIDTH-1 && serial_enable)).
- Handshake occurs at an edge where input_valid && input_ready. The producer holds input_valid and the data stable until the handshake.
- IDLE with handshake: load the word, count=0, go to SHIFT. The first bit appears the cycle after the handshake (latency 1).
- IDLE without handshake: stay in IDLE.
- SHIFT with serial_enable=0: hold the shift register, counter and state. Outputs are unchanged, so the current bit is extended.
- SHIFT with serial_enable=1 and count<WIDTH-1: shift toward the output end (fill with 0) and increment count.
- SHIFT with serial_enable=1 and count==WIDTH-1:
  - With a handshake: load the new word, count=0, stay in SHIFT. Gap-free continuation.
  - Without a handshake: go to IDLE and clear the shift register.
- A consumer samples a bit at edges where serial_valid && serial_enable. Each word occupies exactly WIDTH enabled cycles.
- input_valid while busy and not on the last enabled bit is ignored; the in-flight word is unaffected.
- Counter wraps only via the explicit reload to 0; it never counts past WIDTH-1.

Test Plan:
1. Reset 3 cycles, then 8'hC3 with LSB_FIRST=0, serial_enable=1 -> serial bits 1,1,0,0,0,0,1,1 starting 1 cycle after handshake. frame_start on bit 0, frame_end on bit 7, then IDLE with input_ready=1 and serial_data_output=0.
2. LSB_FIRST=1, word 8'h0F -> bits 1,1,1,1,0,0,0,0. LSB_FIRST=0, same word -> 0,0,0,0,1,1,1,1.
3. 8'hC3 then 8'h5A with input_valid held -> 16 consecutive serial_valid cycles: 1,1,0,0,0,0,1,1,0,1,0,1,1,0,1,0. input_ready=1 only on the two bit-7 cycles; frame_start on cycles 1 and 9.
4. 8'hC3, serial_enable=0 for 3 cycles while bit 3 is on the line -> bit 3 (0) held 4 cycles. Frame spans 11 cycles and the bit sequence is unchanged.
5. sync_reset=1 while bit 4 of 8'hC3 is on the line -> next cycle serial_valid=0 and busy=0, no frame_end. Then 8'h81 transmits cleanly as 1,0,0,0,0,0,0,1.
6. During 8'hC3 transmission, drive input_valid=1 with 8'hFF at bits 2-5 -> input_ready=0 and output unaffected. 8'hFF is accepted only on the bit-7 edge and follows immediately.
